// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Multi-cycle multiply/divide sequencer owning the write side of HI/LO.
//   Accepts MULT/MULTU/DIV/DIVU from EX, stalls the pipeline while busy and
//   issues a single-cycle HI/LO write pulse with the 64-bit result.
//
//   Optional feature macro: HILO_MADD_EN enables MADD (op 4) / MADDU (op 5),
//   which accumulate the product onto the current {HI,LO}.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   command valid from EX (sampled in IDLE only)
//   op        in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU
//   opA/opB   in   rs / rt operands
//   cancel    in   pipeline flush, aborts any operation without a write
//   hiRdData  in   current HI (MADD only)
//   loRdData  in   current LO (MADD only)
//   stallReq  out  pipeline stall request
//   done      out  one-cycle completion pulse
//   div0      out  one-cycle pulse with done on divide by zero
//   hiWtCe    out  HI write enable pulse
//   loWtCe    out  LO write enable pulse
//   hiWtData  out  HI write data (holds between writes)
//   loWtData  out  LO write data (holds between writes)
//
// state | meaning
// IDLE  | waiting for a command
// MUL   | single-cycle product (and MADD accumulate)
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result presented, write pulse unless div0 or cancel

module hilo_muldiv_ctrl #(
  parameter int REG_LENGTH = 32,
  parameter int DIV_CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [REG_LENGTH-1:0] opA,
  input  logic [REG_LENGTH-1:0] opB,
  input  logic                  cancel,
  input  logic [REG_LENGTH-1:0] hiRdData,
  input  logic [REG_LENGTH-1:0] loRdData,
  output logic                  stallReq,
  output logic                  done,
  output logic                  div0,
  output logic                  hiWtCe,
  output logic                  loWtCe,
  output logic [REG_LENGTH-1:0] hiWtData,
  output logic [REG_LENGTH-1:0] loWtData
);

  localparam int W = REG_LENGTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q;
  // During a divide opa_q doubles as the dividend/quotient shift register
  // and opb_q holds the divisor magnitude.
  logic [W-1:0]         opa_q, opb_q;
  logic [W-1:0]         rem_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 q_neg_q, r_neg_q, div0_q;
  logic [W-1:0]         res_hi_q, res_lo_q;

  // Command decode
  logic op_mul, op_div, op_sdiv, accept;
  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    case (op)
      3'd0, 3'd1: op_mul = 1'b1;
      3'd2, 3'd3: op_div = 1'b1;
`ifdef HILO_MADD_EN
      3'd4, 3'd5: op_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign op_sdiv = (op == 3'd2);
  assign accept  = (state_q == S_IDLE) && start && !cancel && (op_mul || op_div);

  logic [W-1:0] a_mag, b_mag;
  assign a_mag = (op_sdiv && opA[W-1]) ? -opA : opA;
  assign b_mag = (op_sdiv && opB[W-1]) ? -opB : opB;

  // Multiply datapath: sign/zero-extend to 2W so one multiplier covers both.
  logic         mul_signed;
  logic [2*W-1:0] ext_a, ext_b, prod, mul_res;
  assign mul_signed = (op_q == 3'd0) || (op_q == 3'd4);
  assign ext_a = mul_signed ? {{W{opa_q[W-1]}}, opa_q} : {{W{1'b0}}, opa_q};
  assign ext_b = mul_signed ? {{W{opb_q[W-1]}}, opb_q} : {{W{1'b0}}, opb_q};
  assign prod  = ext_a * ext_b;

`ifdef HILO_MADD_EN
  assign mul_res = op_q[2] ? (prod + {hiRdData, loRdData}) : prod;
`else
  assign mul_res = prod;
  logic unused_rd;
  assign unused_rd = ^{hiRdData, loRdData};
`endif

  // Restoring divide step: shift next dividend bit into the partial
  // remainder, subtract when it does not borrow.
  logic [W:0]   shifted, diff;
  logic         take, div_last;
  logic [W-1:0] rem_next, quo_next;
  assign shifted  = {rem_q, opa_q[W-1]};
  assign diff     = shifted - {1'b0, opb_q};
  assign take     = !diff[W];
  assign rem_next = take ? diff[W-1:0] : shifted[W-1:0];
  assign quo_next = {opa_q[W-2:0], take};
  assign div_last = (cnt_q == DIV_CNT_W'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_mul ? S_MUL : ((opB == '0) ? S_DONE : S_DIV);
      S_MUL:  state_d = cancel ? S_IDLE : S_DONE;
      S_DIV:  state_d = cancel ? S_IDLE : (div_last ? S_DONE : S_DIV);
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op;
            cnt_q  <= '0;
            rem_q  <= '0;
            div0_q <= op_div && (opB == '0);
            if (op_div) begin
              opa_q   <= a_mag;
              opb_q   <= b_mag;
              q_neg_q <= op_sdiv && (opA[W-1] ^ opB[W-1]);
              r_neg_q <= op_sdiv && opA[W-1];
            end else begin
              opa_q   <= opA;
              opb_q   <= opB;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end
          end
        end
        S_MUL: begin
          if (!cancel) {res_hi_q, res_lo_q} <= mul_res;
        end
        S_DIV: begin
          if (!cancel) begin
            cnt_q <= cnt_q + DIV_CNT_W'(1);
            rem_q <= rem_next;
            opa_q <= quo_next;
            if (div_last) begin
              res_lo_q <= q_neg_q ? -quo_next : quo_next;
              res_hi_q <= r_neg_q ? -rem_next : rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stallReq = 1'b0;
    done     = 1'b0;
    div0     = 1'b0;
    hiWtCe   = 1'b0;
    loWtCe   = 1'b0;
    if (!rst) begin
      stallReq = accept || (state_q == S_MUL) || (state_q == S_DIV);
      if (state_q == S_DONE && !cancel) begin
        done   = 1'b1;
        div0   = div0_q;
        hiWtCe = !div0_q;
        loWtCe = !div0_q;
      end
    end
  end

  assign hiWtData = res_hi_q;
  assign loWtData = res_lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

  logic        clk, rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] opA, opB, hi_rd, lo_rd;
  logic        stallReq, done, div0, hiWtCe, loWtCe;
  logic [31:0] hiWtData, loWtData;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  hilo_muldiv_ctrl #(.REG_LENGTH(32), .DIV_CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .cancel(cancel), .hiRdData(hi_rd), .loRdData(lo_rd),
    .stallReq(stallReq), .done(done), .div0(div0),
    .hiWtCe(hiWtCe), .loWtCe(loWtCe), .hiWtData(hiWtData), .loWtData(loWtData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural op definitions.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic valid, output logic is_div, output logic d0,
                       output logic [31:0] ehi, output logic [31:0] elo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    valid = 1'b0; is_div = 1'b0; d0 = 1'b0; ehi = '0; elo = '0;
    case (o)
      3'd0: begin valid = 1'b1; sp = sa * sb; ehi = sp[63:32]; elo = sp[31:0]; end
      3'd1: begin valid = 1'b1; up = ua * ub; ehi = up[63:32]; elo = up[31:0]; end
      3'd2, 3'd3: begin
        valid = 1'b1; is_div = 1'b1;
        if (b == 0) d0 = 1'b1;
        else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb; elo = sq[31:0]; ehi = sr[31:0];
        end else begin
          elo = a / b; ehi = a % b;
        end
      end
`ifdef HILO_MADD_EN
      3'd4: begin valid = 1'b1; sp = sa * sb + longint'({hi_rd, lo_rd}); ehi = sp[63:32]; elo = sp[31:0]; end
      3'd5: begin valid = 1'b1; up = ua * ub + {hi_rd, lo_rd}; ehi = up[63:32]; elo = up[31:0]; end
`endif
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after completion.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic valid, is_div, d0;
    logic [31:0] ehi, elo;
    int lat;
    model(o, a, b, valid, is_div, d0, ehi, elo);
    lat = !valid ? 0 : (!is_div ? 2 : (d0 ? 1 : 33));
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    chk({tag, "_stall_T"}, stallReq, valid);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); opA = $urandom; opB = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({tag, "_stall"}, stallReq, (k < lat));
      if (k < lat) chk({tag, "_early"}, {done, div0, hiWtCe, loWtCe}, 4'b0000);
      else begin
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_div0"}, div0, d0);
        chk({tag, "_we"}, {hiWtCe, loWtCe}, d0 ? 2'b00 : 2'b11);
        if (!d0) begin mdl_hi = ehi; mdl_lo = elo; end
        chk({tag, "_hilo"}, {hiWtData, loWtData}, {mdl_hi, mdl_lo});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_after"}, {stallReq, done, div0, hiWtCe, loWtCe}, 5'b0);
    @(posedge clk); #1;
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if ({stallReq, done, div0, hiWtCe, loWtCe} != 5'b0) bad++;
      @(posedge clk); #1;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; opA = '0; opB = '0;
    hi_rd = '0; lo_rd = '0;
    repeat (2) @(posedge clk);
    start = 1'b1; opB = 32'd3;
    @(negedge clk);
    chk("reset_out", {stallReq, done, div0, hiWtCe, loWtCe, hiWtData, loWtData}, '0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);
    do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    do_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    do_op("div_wrap", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_zero", 3'd2, 32'd5, 32'd0);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("bad_op6", 3'd6, 32'd9, 32'd9);

    // Cancel wins over a same-cycle start.
    start = 1'b1; cancel = 1'b1; op = 3'd0; opA = 32'd2; opB = 32'd2;
    @(negedge clk);
    chk("cancel_start_stall", stallReq, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    quiet("cancel_start_quiet", 4);

    // Cancel a DIVU when its counter reaches 10.
    start = 1'b1; op = 3'd3; opA = 32'd1000; opB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_div_stall_now", stallReq, 1'b1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_div_stall_next", stallReq, 1'b0);
    @(posedge clk); #1;
    quiet("cancel_div_quiet", 30);
    do_op("multu_3_4", 3'd1, 32'd3, 32'd4);

    // Cancel during DONE suppresses done and write.
    start = 1'b1; op = 3'd1; opA = 32'd6; opB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_done", {done, div0, hiWtCe, loWtCe}, 4'b0);
    @(posedge clk); #1;
    cancel = 1'b0;
    quiet("cancel_done_quiet", 3);

    // Reset when the divide counter reaches 20.
    start = 1'b1; op = 3'd2; opA = 32'hFFFF_0000; opB = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_out", {stallReq, done, div0, hiWtCe, loWtCe, hiWtData, loWtData}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    quiet("rst_mid_quiet", 20);

`ifdef HILO_MADD_EN
    hi_rd = 32'h0; lo_rd = 32'hFFFF_FFFF;
    do_op("maddu_1_1", 3'd5, 32'd1, 32'd1);
    hi_rd = 32'h1234_5678; lo_rd = 32'h9ABC_DEF0;
    do_op("madd_neg", 3'd4, 32'hFFFF_FFFE, 32'd3);
`else
    do_op("op4_ignored", 3'd4, 32'd1, 32'd1);
    do_op("op5_ignored", 3'd5, 32'd1, 32'd1);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      hi_rd = $urandom; lo_rd = $urandom;
      do_op("rand", o, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
